// File: rtl/operand_mem_pkg.sv
//------------------------------------------------------------------------------
// Module   : operand_mem_pkg
// Purpose  : Shared constants and types for the operand memory block.
//            Holds the default data and address widths, the latency counter
//            width and the request FSM state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package operand_mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  // Wide enough for the largest supported latency (7).
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } opmem_state_t;

endpackage

`default_nettype wire

// File: rtl/operand_mem_array.sv
//------------------------------------------------------------------------------
// Module   : operand_mem_array
// Purpose  : 2**ADDR_W x DATA_W register file with asynchronous clear.
//            One synchronous write port, one combinational read port.
// Ports    : clk, rst_n       - clock, async active-low clear of all entries
//            we, waddr, wdata - write port (commits on rising clk)
//            raddr, rdata     - combinational read port
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module operand_mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0][DATA_W-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/operand_memory.sv
//------------------------------------------------------------------------------
// Module   : operand_memory
// Purpose  : Responder-side operand memory. Accepts one read/write request
//            over a valid/ready handshake, waits a fixed latency, performs the
//            access and presents the result until the requester takes it.
// Ports    : clk, rst_n                          - clock, async active-low reset
//            req_valid/req_ready                 - request handshake
//            req_we, req_addr, req_wdata         - request payload
//            rsp_valid/rsp_ready, rsp_rdata      - response handshake + data
//            busy                                - FSM not in IDLE
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module operand_memory
  import operand_mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  // WAIT lasts LATENCY+1 cycles: the counter is loaded with LATENCY, counts
  // down to zero, and the access happens on the edge that sees zero.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

  opmem_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              access;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Access source: with zero latency the access happens on the accept edge,
  // so it must use the live request rather than the (not yet loaded) latches.
  always_comb begin
    if (LATENCY == 0) begin
      access    = req_valid && (state_q == IDLE);
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      access    = (state_q == WAIT) && (cnt_q == '0);
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Writes echo the written value so the requester sees what was stored.
    if (access) begin
      rdata_d = acc_we ? acc_wdata : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  operand_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (access && acc_we),
    .waddr (acc_addr),
    .wdata (acc_wdata),
    .raddr (acc_addr),
    .rdata (mem_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_memory.sv
//------------------------------------------------------------------------------
// Module   : tb_operand_memory
// Purpose  : Self-checking bench for operand_memory. Instance 0 uses
//            LATENCY=2, instance 1 uses LATENCY=0. Requests push expected
//            responses into per-instance queues; a monitor pops and compares.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_operand_memory;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rv  [2];
  logic       rw  [2];
  logic [3:0] ra  [2];
  logic [7:0] rwd [2];
  logic       rr  [2];
  logic       qr  [2];
  logic       sv  [2];
  logic [7:0] srd [2];
  logic       bsy [2];

  operand_memory #(.DATA_W(8), .ADDR_W(4), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[0]), .req_ready(qr[0]), .req_we(rw[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]),
    .rsp_valid(sv[0]), .rsp_ready(rr[0]), .rsp_rdata(srd[0]),
    .busy(bsy[0])
  );

  operand_memory #(.DATA_W(8), .ADDR_W(4), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[1]), .req_ready(qr[1]), .req_we(rw[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]),
    .rsp_valid(sv[1]), .rsp_ready(rr[1]), .rsp_rdata(srd[1]),
    .busy(bsy[1])
  );

  typedef struct {
    logic [7:0] data;
    int         acc;   // index of the accept edge
    int         rise;  // edges from accept to the edge that raises rsp_valid
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  bit   seen [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle a response is presented its data is compared with
  // the head of the queue (so backpressure stalls are checked for stability);
  // the first cycle also checks the latency; the handshake pops.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (sv[d]) begin
          exp_t e;
          int   n;
          n = (d == 0) ? sb0.size() : sb1.size();
          if (n == 0) begin
            chk($sformatf("unexpected_rsp_%0d", d), 32'd1, 32'd0);
          end else begin
            e = (d == 0) ? sb0[0] : sb1[0];
            chk($sformatf("rsp_rdata_%0d", d), {24'd0, srd[d]}, {24'd0, e.data});
            if (!seen[d]) begin
              chk($sformatf("rsp_latency_%0d", d), cyc - e.acc, e.rise);
              seen[d] = 1'b1;
            end
            if (rr[d]) begin
              seen[d] = 1'b0;
              if (d == 0) void'(sb0.pop_front());
              else        void'(sb1.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic issue(input int d, input bit we, input logic [3:0] a,
                       input logic [7:0] wd, input logic [7:0] ed, output int acc);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    rv[d] = 1'b1; rw[d] = we; ra[d] = a; rwd[d] = wd;
    while (!qr[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!qr[d]) begin
      chk($sformatf("req_ready_timeout_%0d", d), 32'd0, 32'd1);
      rv[d] = 1'b0;
      acc = -1;
      return;
    end
    acc    = cyc + 1;
    e.data = ed;
    e.acc  = acc;
    e.rise = (d == 0) ? 3 : 0;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    @(posedge clk);
    #1;
    // Scramble the request inputs after the accept edge.
    rv[d] = 1'b0; rw[d] = ~we; ra[d] = ~a; rwd[d] = ~wd;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while (((d == 0) ? sb0.size() : sb1.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("rsp_timeout_%0d", d), ((d == 0) ? sb0.size() : sb1.size()), 0);
  endtask

  task automatic check_idle(input int d, input string tag);
    chk({tag, "_req_ready"}, {31'd0, qr[d]}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, sv[d]}, 32'd0);
    chk({tag, "_rsp_rdata"}, {24'd0, srd[d]}, 32'd0);
    chk({tag, "_busy"},      {31'd0, bsy[d]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, n;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = '0; rwd[d] = '0; rr[d] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "reset_l2");
    check_idle(1, "reset_l0");

    // Cleared memory, then write/read round trip with echo of written data.
    issue(0, 1'b0, 4'd7, 8'h00, 8'h00, a1); wait_done(0);
    issue(0, 1'b1, 4'd3, 8'hA5, 8'hA5, a1); wait_done(0);
    issue(0, 1'b0, 4'd3, 8'h00, 8'hA5, a1); wait_done(0);
    issue(0, 1'b1, 4'd15, 8'h3C, 8'h3C, a1); wait_done(0);

    // Backpressure: response must hold while rsp_ready is low.
    @(posedge clk); #1 rr[0] = 1'b0;
    issue(0, 1'b0, 4'd15, 8'h00, 8'h3C, a1);
    n = 0;
    while (!sv[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid", {31'd0, sv[0]}, 32'd1);
    repeat (3) @(negedge clk);
    chk("bp_still_valid", {31'd0, sv[0]}, 32'd1);
    @(posedge clk); #1 rr[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_req_ready", {31'd0, qr[0]}, 32'd1);
    chk("bp_idle_busy", {31'd0, bsy[0]}, 32'd0);

    // Busy rejection: a write offered during WAIT must be ignored.
    issue(0, 1'b1, 4'd1, 8'h22, 8'h22, a1);
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 4'd0; rwd[0] = 8'hFF;
    chk("rej_req_ready", {31'd0, qr[0]}, 32'd0);
    chk("rej_busy", {31'd0, bsy[0]}, 32'd1);
    @(negedge clk);
    chk("rej_req_ready2", {31'd0, qr[0]}, 32'd0);
    #1 rv[0] = 1'b0;
    wait_done(0);
    issue(0, 1'b0, 4'd0, 8'h00, 8'h00, a1); wait_done(0);
    issue(0, 1'b0, 4'd1, 8'h00, 8'h22, a1); wait_done(0);

    // Reset mid-WAIT: in-flight write discarded, memory cleared.
    issue(0, 1'b1, 4'd5, 8'h11, 8'h11, a1);
    @(negedge clk);
    rst_n = 1'b0;
    sb0.delete();
    seen[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_no_rsp_valid", {31'd0, sv[0]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "midrst_l2");
    repeat (4) @(negedge clk);
    chk("midrst_no_rsp_valid", {31'd0, sv[0]}, 32'd0);
    issue(0, 1'b0, 4'd5, 8'h00, 8'h00, a1); wait_done(0);
    issue(0, 1'b0, 4'd3, 8'h00, 8'h00, a1); wait_done(0);

    // LATENCY=0: back-to-back accesses every 2 cycles with rsp_ready high.
    issue(1, 1'b1, 4'd9, 8'h5A, 8'h5A, a1);
    issue(1, 1'b0, 4'd9, 8'h00, 8'h5A, a2);
    issue(1, 1'b0, 4'd3, 8'h00, 8'h00, a3);
    wait_done(1);
    chk("l0_spacing_1", a2 - a1, 2);
    chk("l0_spacing_2", a3 - a2, 2);
    @(negedge clk);
    check_idle(1, "l0_end_zero_rdata_after_read");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
